fft_sink_out: RTL and testbench
===============================

Name: fft_sink_out

Overview:
Receive-side counterpart of the FFT source feeder. Accepts one FFT output frame from the FFT core's master AXI-stream (data/valid/last/ready) and captures it into an on-chip buffer. Tracks frame length and the peak bin, then holds the frame for random-access readback by the control/UART logic. Sits between the FFT core output and the result reader in the Burst_FFT_IFFT apply path.

Parameters:
FFT_LENGTH, 1024, points per frame (power of two, >= 8)
DATA_WIDTH, 32, beat width; [DATA_WIDTH/2-1:0] = real, [DATA_WIDTH-1:DATA_WIDTH/2] = imag, both two's complement
ADDR_WIDTH, 10, log2(FFT_LENGTH)

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
arm  in  1  one-cycle pulse: start/restart capture of the next frame
m_axi_data  in  DATA_WIDTH  FFT output beat
m_axi_valid  in  1  beat valid
m_axi_last  in  1  final beat of frame
m_axi_ready  out  1  sink ready
frame_done  out  1  one-cycle pulse when frame is complete
busy  out  1  high in CAPTURE or DRAIN
len_err  out  1  last frame ended with a length mismatch (sticky until next arm)
frame_len  out  ADDR_WIDTH+1  beats stored in last frame
peak_bin  out  ADDR_WIDTH  bin index of max magnitude
peak_mag  out  DATA_WIDTH/2+1  max |re|+|im|
rd_en  in  1  buffer read enable
rd_addr  in  ADDR_WIDTH  buffer read address
rd_data  out  DATA_WIDTH  read data, 1-cycle latency

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, m_axi_ready=0, frame_done=0, busy=0, len_err=0, frame_len=0, peak_bin=0, peak_mag=0, rd_data=0, wr_addr=0. Buffer contents are not cleared. Reset mid-frame aborts capture with no frame_done.
- Beat = m_axi_valid & m_axi_ready. m_axi_ready is a registered function of state: 1 in CAPTURE and DRAIN, 0 otherwise.
- IDLE: on arm -> CAPTURE; clear wr_addr, peak_bin, peak_mag, len_err.
- CAPTURE: each beat writes m_axi_data to buffer[wr_addr] and increments wr_addr.
  - Beat with m_axi_last and wr_addr==FFT_LENGTH-1 -> DONE, frame_len=FFT_LENGTH, len_err=0.
  - Beat with m_axi_last and wr_addr<FFT_LENGTH-1 (early last) -> DONE, frame_len=wr_addr+1, len_err=1.
  - Beat without m_axi_last at wr_addr==FFT_LENGTH-1 (missing last) -> DRAIN, frame_len=FFT_LENGTH, len_err=1.
- DRAIN: m_axi_ready=1; beats are discarded and not written; beat with m_axi_last -> DONE.
- DONE: frame_done pulses on the first cycle only; ready=0; frame held indefinitely; arm -> CAPTURE (re-arm with same clears as IDLE).
- arm in CAPTURE/DRAIN is ignored.
- Peak tracking runs on every CAPTURE beat:
  - mag = |re| + |im|, computed unsigned at DATA_WIDTH/2+1 bits; |-2^(N-1)| = 2^(N-1) with no saturation.
  - Update only when mag > peak_mag (strict), so on ties the lowest bin wins.
  - peak_bin = address written on that beat.
  - peak_* are final on the same cycle frame_done is asserted.
- Read port works in any state. rd_data is registered and valid the cycle after rd_en. It holds its value when rd_en=0. Read/write to the same address in the same cycle returns the old data (read-first).
- wr_addr never wraps inside a frame; transition to DRAIN prevents overrun.

Decomposition:
- Package fft_sink_pkg holds:
  - state enum IDLE/CAPTURE/DRAIN/DONE (2 bits)
  - localparam for half width (DATA_WIDTH/2)
  - localparam for magnitude width (DATA_WIDTH/2+1)
  - abs-sum helper function
- One sub-module, fft_sink_ram: simple dual-port RAM, FFT_LENGTH x DATA_WIDTH, sync write port, registered read port, read-first. Inferable, or maps to vendor DRM.

Test Plan:
- FFT_LENGTH=16. arm, 16 beats data[i]={16'h0,16'(i)}, last on beat 15, valid continuous -> frame_done at the cycle after beat 15; frame_len=16, len_err=0; reads addr 0..15 return i one cycle after rd_en; peak_bin=15, peak_mag=15.
- Same frame with random valid gaps and beat 7 = {16'h8000,16'h0001} -> peak_mag=32769, peak_bin=7; all 16 words stored in order.
- Early last on beat 9 (index 9) -> frame_done, frame_len=10, len_err=1, m_axi_ready=0 afterwards.
- 20 beats with last only on beat 19 -> buffer holds beats 0..15 only; ready stays high through beat 19; frame_done after beat 19; frame_len=16, len_err=1.
- Ties: beats 3 and 11 both magnitude 100, all others lower -> peak_bin=3. Then arm in DONE plus a new frame -> peak cleared and recomputed, len_err cleared.
- rst_n low at beat 5 mid-capture -> next cycle m_axi_ready=0, busy=0, no frame_done. Beats without arm are not accepted; arm then a full frame captures normally.

Source files
------------

// File: rtl/fft_sink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_pkg                                                    |
// | Purpose  : Shared types, widths and the |re|+|im| helper for the FFT       |
// |            output sink.                                                    |
// | Contents : state_t            capture FSM states                           |
// |            c_DATA_WIDTH       default beat width                           |
// |            c_HALF_W           width of one real/imag component             |
// |            c_MAG_W            width of |re|+|im|                           |
// |            c_ABS_IN_W         operand width accepted by abs_sum()          |
// |            abs_sum()          unsigned |re| + |im|                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fft_sink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_HALF_W     = c_DATA_WIDTH / 2;
    localparam int c_MAG_W      = c_HALF_W + 1;

    // abs_sum() works on operands sign-extended to this width, so any
    // component width up to c_ABS_IN_W can share the same helper.
    localparam int c_ABS_IN_W   = 32;

    // |re| + |im| without saturation. Taking the magnitude one bit wider than
    // the operand lets the most negative value map to +2^(W-1) exactly.
    // Callers whose components are narrower than c_ABS_IN_W keep the low
    // (component width + 1) bits, which always hold the full sum.
    function automatic logic [c_ABS_IN_W:0] abs_sum(
        input logic [c_ABS_IN_W-1:0] re,
        input logic [c_ABS_IN_W-1:0] im
    );
        logic [c_ABS_IN_W:0] a;
        logic [c_ABS_IN_W:0] b;
        a = re[c_ABS_IN_W-1] ? ((c_ABS_IN_W+1)'(0) - {1'b1, re}) : {1'b0, re};
        b = im[c_ABS_IN_W-1] ? ((c_ABS_IN_W+1)'(0) - {1'b1, im}) : {1'b0, im};
        return a + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_if                                                     |
// | Purpose  : AXI-stream style link from the FFT core output to the sink.     |
// | Signals  : data   beat payload, imag in upper half, real in lower half     |
// |            valid  beat valid (from FFT core)                               |
// |            last   final beat of frame (from FFT core)                      |
// |            ready  sink can accept (from sink)                              |
// | Modports : master  FFT core side                                           |
// |            slave   sink side                                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fft_sink_if
    import fft_sink_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/fft_sink_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_ram                                                    |
// | Purpose  : Simple dual-port frame buffer, one synchronous write port and   |
// |            one registered read port, read-first on address collision.      |
// | Ports    : clk        clock                                                |
// |            rst_n      synchronous active-low reset (read register only)    |
// |            i_wr_en    write strobe                                         |
// |            i_wr_addr  write address                                        |
// |            i_wr_data  write data                                           |
// |            i_rd_en    read strobe; output register holds when low          |
// |            i_rd_addr  read address                                         |
// |            o_rd_data  read data, one cycle after i_rd_en                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fft_sink_ram #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    input  wire logic                  i_rd_en,
    input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);

    // Storage is never reset so the array maps onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the array in the same edge as a write gives the
    // pre-write contents, i.e. read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_sink_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_sink_out                                                    |
// | Purpose  : Captures one FFT output frame from the core's stream into a     |
// |            buffer, tracks its length and peak |re|+|im| bin, then holds it |
// |            for random-access readback.                                     |
// | Ports    : clk         clock                                               |
// |            rst_n       synchronous active-low reset                        |
// |            arm         pulse: capture the next frame (IDLE/DONE only)      |
// |            m_axi       stream from FFT core (slave side)                   |
// |            frame_done  one-cycle pulse on frame completion                 |
// |            busy        high while capturing or draining                    |
// |            len_err     last frame had a length mismatch                    |
// |            frame_len   beats stored from the last frame                    |
// |            peak_bin    bin of the largest magnitude (lowest on ties)       |
// |            peak_mag    largest |re|+|im|                                   |
// |            rd_en       buffer read strobe                                  |
// |            rd_addr     buffer read address                                 |
// |            rd_data     buffer read data, one cycle after rd_en             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fft_sink_out
    import fft_sink_pkg::*;
#(
    parameter int FFT_LENGTH = 1024,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    arm,
    fft_sink_if.slave                    m_axi,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         len_err,
    output logic [ADDR_WIDTH:0]          frame_len,
    output logic [ADDR_WIDTH-1:0]        peak_bin,
    output logic [DATA_WIDTH/2:0]        peak_mag,
    input  wire logic                    rd_en,
    input  wire logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    localparam int HALF_W = DATA_WIDTH / 2;
    localparam int MAG_W  = HALF_W + 1;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FFT_LENGTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_FULL_LEN  = (ADDR_WIDTH + 1)'(FFT_LENGTH);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_len_err;
    logic [ADDR_WIDTH:0]   r_frame_len;
    logic [ADDR_WIDTH-1:0] r_peak_bin;
    logic [MAG_W-1:0]      r_peak_mag;
    logic [ADDR_WIDTH-1:0] r_wr_addr;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic                  w_beat;
    logic                  w_start;
    logic                  w_cap_beat;
    logic                  w_at_end;
    logic                  w_wr_en;
    logic [ADDR_WIDTH:0]   w_len_early;
    logic signed [HALF_W-1:0] w_re;
    logic signed [HALF_W-1:0] w_im;
    logic [MAG_W-1:0]      w_mag;

    // ready is registered, so a beat is simply valid while ready is up.
    assign w_beat      = m_axi.valid & r_ready;
    assign w_at_end    = (r_wr_addr == c_LAST_ADDR);
    assign w_len_early = {1'b0, r_wr_addr} + (ADDR_WIDTH + 1)'(1);

    // Components are sign-extended to the helper's operand width; the low
    // MAG_W bits of the sum are exact for any HALF_W <= c_ABS_IN_W.
    assign w_re  = m_axi.data[HALF_W-1:0];
    assign w_im  = m_axi.data[DATA_WIDTH-1:HALF_W];
    assign w_mag = MAG_W'(abs_sum(c_ABS_IN_W'(w_re), c_ABS_IN_W'(w_im)));

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cap_beat  = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (arm) begin
                    w_start     = 1'b1;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_beat) begin
                    w_cap_beat = 1'b1;
                    if (m_axi.last) begin
                        w_state_nxt = DONE;
                    end else if (w_at_end) begin
                        // Buffer is full but the core keeps sending: swallow
                        // the rest of its frame instead of wrapping.
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_beat && m_axi.last) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Writes are suppressed during reset so an aborted frame leaves no
    // partial write from the reset edge itself.
    assign w_wr_en = w_cap_beat & rst_n;

    // ------------------------------------------------------------------
    // FSM state register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_len <= '0;
            r_peak_bin  <= '0;
            r_peak_mag  <= '0;
            r_wr_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == CAPTURE) || (w_state_nxt == DRAIN);
            // Pulse only on entry, the DONE state itself may last forever.
            r_done  <= (w_state_nxt == DONE) && (r_state != DONE);

            if (w_start) begin
                r_wr_addr  <= '0;
                r_peak_bin <= '0;
                r_peak_mag <= '0;
                r_len_err  <= 1'b0;
            end else if (w_cap_beat) begin
                // Strict compare keeps the earliest bin on ties.
                if (w_mag > r_peak_mag) begin
                    r_peak_mag <= w_mag;
                    r_peak_bin <= r_wr_addr;
                end
                if (m_axi.last) begin
                    r_frame_len <= w_at_end ? c_FULL_LEN : w_len_early;
                    r_len_err   <= ~w_at_end;
                end else if (w_at_end) begin
                    r_frame_len <= c_FULL_LEN;
                    r_len_err   <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    fft_sink_ram #(
        .DEPTH      (FFT_LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (m_axi.data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axi.ready = r_ready;
    assign frame_done  = r_done;
    assign busy        = (r_state == CAPTURE) || (r_state == DRAIN);
    assign len_err     = r_len_err;
    assign frame_len   = r_frame_len;
    assign peak_bin    = r_peak_bin;
    assign peak_mag    = r_peak_mag;

endmodule
`default_nettype wire

// File: tb/tb_fft_sink_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_sink_out                                                 |
// | Purpose  : Scoreboard bench for fft_sink_out with a 16-point frame.        |
// |            Stimulus pushes expected frame results and read data into       |
// |            queues; a negedge monitor pops and compares whenever the DUT    |
// |            pulses frame_done or returns read data.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fft_sink_out;
    import fft_sink_pkg::*;

    localparam int L  = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           arm;
    logic           frame_done;
    logic           busy;
    logic           len_err;
    logic [AW:0]    frame_len;
    logic [AW-1:0]  peak_bin;
    logic [c_MAG_W-1:0] peak_mag;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;

    fft_sink_if #(.DATA_WIDTH(DW)) m_axi_if ();

    fft_sink_out #(
        .FFT_LENGTH (L),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .m_axi      (m_axi_if),
        .frame_done (frame_done),
        .busy       (busy),
        .len_err    (len_err),
        .frame_len  (frame_len),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int err;
        int bin;
        int mag;
        int done_cyc;
    } frame_rec_t;

    frame_rec_t      sb_frames[$];
    logic [DW-1:0]   sb_reads[$];
    logic [DW-1:0]   tx[$];
    logic [DW-1:0]   exp_mem[L];
    frame_rec_t      pending;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    logic            rd_en_d = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_en_d <= rd_en;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares whenever the DUT presents a result
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (sb_frames.size() == 0) begin
                fail("unexpected_frame_done");
            end else begin
                frame_rec_t r;
                r = sb_frames.pop_front();
                chk("frame_len",  64'(frame_len), 64'(r.len));
                chk("len_err",    64'(len_err),   64'(r.err));
                chk("peak_bin",   64'(peak_bin),  64'(r.bin));
                chk("peak_mag",   64'(peak_mag),  64'(r.mag));
                chk("done_cycle", 64'(cyc),       64'(r.done_cyc));
                chk("ready_at_done", 64'(m_axi_if.ready), 64'(0));
                chk("busy_at_done",  64'(busy),           64'(0));
            end
        end
        if (rd_en_d) begin
            if (sb_reads.size() == 0) begin
                fail("unexpected_read");
            end else begin
                chk("rd_data", 64'(rd_data), 64'(sb_reads.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: frame result from the spec's rules, plain arithmetic
    // ------------------------------------------------------------------
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_frame(input int n);
        int stored;
        int best;
        int bin;
        stored = (n < L) ? n : L;
        best = 0;
        bin  = 0;
        for (int i = 0; i < stored; i++) begin
            logic signed [15:0] re16;
            logic signed [15:0] im16;
            int m;
            exp_mem[i] = tx[i];
            re16 = tx[i][15:0];
            im16 = tx[i][31:16];
            m = iabs(int'(re16)) + iabs(int'(im16));
            if (m > best) begin
                best = m;
                bin  = i;
            end
        end
        pending.len = stored;
        pending.err = (n != L) ? 1 : 0;
        pending.bin = bin;
        pending.mag = best;
        pending.done_cyc = 0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered and left at a negedge)
    // ------------------------------------------------------------------
    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_busy",    64'(busy),           64'(1));
        chk("arm_ready",   64'(m_axi_if.ready), 64'(1));
        chk("arm_len_err", 64'(len_err),        64'(0));
        chk("arm_peak",    64'(peak_mag),       64'(0));
    endtask

    task automatic drive_beats(input int n, input int last_idx, input int gap_pct, input bit rec);
        for (int i = 0; i < n; i++) begin
            int t;
            while ($urandom_range(0, 99) < gap_pct) begin
                m_axi_if.valid = 1'b0;
                @(negedge clk);
            end
            m_axi_if.data  = tx[i];
            m_axi_if.last  = (i == last_idx);
            m_axi_if.valid = 1'b1;
            t = 0;
            while (m_axi_if.ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (m_axi_if.ready !== 1'b1) begin
                fail("ready_timeout");
                m_axi_if.valid = 1'b0;
                m_axi_if.last  = 1'b0;
                return;
            end
            if (rec && i == last_idx) begin
                pending.done_cyc = cyc + 1;
                sb_frames.push_back(pending);
            end
            @(negedge clk);
        end
        m_axi_if.valid = 1'b0;
        m_axi_if.last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb_frames.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb_frames.size() != 0) begin
            fail("frame_done_timeout");
            sb_frames.delete();
        end
    endtask

    task automatic run_frame(input int n, input int gap_pct);
        model_frame(n);
        do_arm();
        drive_beats(n, n - 1, gap_pct, 1'b1);
        wait_done();
    endtask

    task automatic readback(input int gap_pct);
        for (int a = 0; a < L; a++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                rd_en = 1'b0;
                @(negedge clk);
            end
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            sb_reads.push_back(exp_mem[a]);
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_hold", 64'(rd_data), 64'(exp_mem[L-1]));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        arm   = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        m_axi_if.data  = '0;
        m_axi_if.valid = 1'b1;
        m_axi_if.last  = 1'b0;
        for (int i = 0; i < L; i++) exp_mem[i] = '0;
        repeat (3) @(negedge clk);

        // Reset values; valid is high but nothing is accepted before arm.
        chk("rst_ready",     64'(m_axi_if.ready), 64'(0));
        chk("rst_busy",      64'(busy),           64'(0));
        chk("rst_done",      64'(frame_done),     64'(0));
        chk("rst_len_err",   64'(len_err),        64'(0));
        chk("rst_frame_len", 64'(frame_len),      64'(0));
        chk("rst_peak_bin",  64'(peak_bin),       64'(0));
        chk("rst_peak_mag",  64'(peak_mag),       64'(0));
        chk("rst_rd_data",   64'(rd_data),        64'(0));
        rst_n = 1'b1;
        m_axi_if.valid = 1'b0;
        @(negedge clk);

        // Ramp frame, continuous valid.
        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back(DW'(i));
        run_frame(L, 0);
        readback(0);

        // Ramp with a large negative imag at bin 7 and random valid gaps.
        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back(DW'(i));
        tx[7] = 32'h8000_0001;
        run_frame(L, 40);
        readback(30);

        // Early last at index 9.
        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back(32'h0100_0000 + DW'(i * 5));
        run_frame(10, 20);
        repeat (3) @(negedge clk);
        chk("ready_after_early", 64'(m_axi_if.ready), 64'(0));
        readback(0);

        // Missing last: 20 beats, last only on beat 19.
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back($urandom());
        run_frame(20, 25);
        readback(20);

        // Tie at magnitude 100 on bins 3 and 11, all others lower.
        tx.delete();
        for (int i = 0; i < L; i++) begin
            int re;
            int im;
            re = int'($urandom_range(0, 98)) - 49;
            im = int'($urandom_range(0, 98)) - 49;
            tx.push_back({16'(im), 16'(re)});
        end
        tx[3]  = {16'h0000, 16'd100};
        tx[11] = {16'h0032, 16'hFFCE};
        run_frame(L, 30);

        // Re-arm from DONE with fully random data.
        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back($urandom());
        run_frame(L, 30);
        readback(10);

        // Reset in the middle of a frame.
        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back($urandom());
        do_arm();
        drive_beats(5, -1, 0, 1'b0);
        m_axi_if.data  = tx[5];
        m_axi_if.valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 64'(m_axi_if.ready), 64'(0));
        chk("abort_busy",  64'(busy),           64'(0));
        repeat (5) @(negedge clk);
        chk("no_arm_ready", 64'(m_axi_if.ready), 64'(0));
        chk("no_arm_busy",  64'(busy),           64'(0));
        m_axi_if.valid = 1'b0;

        tx.delete();
        for (int i = 0; i < L; i++) tx.push_back($urandom());
        run_frame(L, 20);
        readback(0);

        repeat (3) @(negedge clk);
        chk("sb_frames_empty", 64'(sb_frames.size()), 64'(0));
        chk("sb_reads_empty",  64'(sb_reads.size()),  64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
